instruction_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined core; sits directly upstream of the IF/ID pipeline buffer.
- Owns the PC register and issues one-outstanding-request reads to instruction memory through a req/ready handshake.
- Holds each returned instruction with its updated PC (PC+2) until the IF/ID stage consumes it.
- Applies branch redirects and generates the IFFlush pulse that the IF/ID buffer uses to insert a bubble.

---
 rtl/instruction_fetch_unit_pkg.sv | 8 +
 rtl/instruction_fetch_unit_pc_register.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: core-wide widths, fetch constants and fetch-state encoding.
package instruction_fetch_unit_pkg;
    localparam int          PC_W          = 16;
    localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
    localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;
    localparam logic [15:0] DEF_PC_STEP   = 16'd2;
    typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// instruction_fetch_unit_pc_register: program counter with redirect and PC+step incrementer.
module instruction_fetch_unit_pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] P_RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] P_STEP     = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_inc,
    input  logic            i_branch,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_inc
);
    logic [PC_W-1:0] r_pc;

    assign o_pc     = r_pc;
    assign o_pc_inc = r_pc + P_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc <= P_RESET_PC;
        else if (i_branch) r_pc <= i_target;
        else if (i_inc)    r_pc <= o_pc_inc;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC ownership, one-outstanding imem fetch, redirect handling and IFFlush.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [PC_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [PC_W-1:0] PC_STEP   = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            branchTaken,
    input  logic [PC_W-1:0] branchTarget,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemReady,
    input  logic [PC_W-1:0] imemData,
    output logic [PC_W-1:0] instruction,
    output logic [PC_W-1:0] updatedPC,
    output logic            fetchValid,
    output logic            IFFlush
);
    fetch_state_t    r_state, w_next_state;
    logic [PC_W-1:0] r_instr, r_upc, r_drop_addr, w_pc, w_pc_inc;
    logic            r_valid, r_flush, w_req, w_load, w_clear, w_drop;

    instruction_fetch_unit_pc_register #(.P_RESET_PC(RESET_PC), .P_STEP(PC_STEP)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_load),
        .i_branch (branchTaken),
        .i_target (branchTarget),
        .o_pc     (w_pc),
        .o_pc_inc (w_pc_inc)
    );

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (branchTaken) begin
                    w_drop       = !imemReady;
                    w_next_state = imemReady ? FETCH : DROP;
                end else if (imemReady) begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    w_clear      = 1'b1;
                    w_next_state = FETCH;
                end else if (PCWrite) begin
                    w_req        = 1'b1;
                    w_load       = imemReady;
                    w_clear      = !imemReady;
                    w_next_state = imemReady ? HOLD : FETCH;
                end
            end
            DROP: begin
                w_req        = 1'b1;
                w_next_state = imemReady ? FETCH : DROP;
            end
            default: w_next_state = FETCH;
        endcase
    end

    // A stale request keeps its original address until memory answers it.
    assign imemReq     = rst_n & w_req;
    assign imemAddr    = (r_state == DROP) ? r_drop_addr : w_pc;
    assign instruction = r_instr;
    assign updatedPC   = r_upc;
    assign fetchValid  = r_valid;
    assign IFFlush     = r_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_instr     <= NOP_INSTR;
            r_upc       <= '0;
            r_valid     <= 1'b0;
            r_flush     <= 1'b0;
            r_drop_addr <= '0;
        end else begin
            r_state <= w_next_state;
            r_flush <= branchTaken;
            if (w_drop) r_drop_addr <= w_pc;
            if (w_load) begin
                r_instr <= imemData;
                r_upc   <= w_pc_inc;
                r_valid <= 1'b1;
            end else if (w_clear) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random fetch sequences checked against a held/stale-request model.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b0, branchTaken = 1'b0, imemReady = 1'b0;
    logic [15:0] branchTarget = '0, imemData = '0;
    logic        imemReq, fetchValid, IFFlush;
    logic [15:0] imemAddr, instruction, updatedPC;

    int total = 0;
    int bad   = 0;

    // Model: the PC, whether a fetch is held, and whether a dead request is still pending.
    logic [15:0] m_pc, m_instr, m_upc, m_stale_addr;
    logic        m_held, m_stale, m_flush;

    instruction_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCWrite      (PCWrite),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemReady    (imemReady),
        .imemData     (imemData),
        .instruction  (instruction),
        .updatedPC    (updatedPC),
        .fetchValid   (fetchValid),
        .IFFlush      (IFFlush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_upc = 16'h0000;
        m_stale_addr = 16'h0000; m_held = 0; m_stale = 0; m_flush = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, {15'd0, fetchValid}, {15'd0, m_held});
        chk({tag, ".instr"}, instruction, m_instr);
        chk({tag, ".upc"}, updatedPC, m_upc);
        chk({tag, ".flush"}, {15'd0, IFFlush}, {15'd0, m_flush});
    endtask

    // Called 1ns after a rising edge: drive, check request side, clock, check held side.
    task automatic step(input logic pcw, input logic br, input logic [15:0] tgt, input logic rdy);
        logic        e_req;
        logic [15:0] e_addr, data;
        e_req  = m_held ? (pcw && !br) : 1'b1;
        e_addr = m_stale ? m_stale_addr : m_pc;
        data   = e_addr ^ 16'hA5A5;
        PCWrite = pcw; branchTaken = br; branchTarget = tgt; imemReady = rdy; imemData = data;
        #1;
        chk("req", {15'd0, imemReq}, {15'd0, e_req});
        chk("addr", imemAddr, e_addr);
        @(posedge clk);
        m_flush = br;
        if (m_stale) begin
            if (rdy) m_stale = 0;
            if (br) m_pc = tgt;
        end else if (!m_held) begin
            if (br) begin
                if (!rdy) begin m_stale = 1; m_stale_addr = m_pc; end
                m_pc = tgt;
            end else if (rdy) begin
                m_held = 1; m_instr = data; m_pc = m_pc + 16'd2; m_upc = m_pc;
            end
        end else if (br) begin
            m_held = 0; m_instr = 16'h0000; m_pc = tgt;
        end else if (pcw) begin
            if (rdy) begin m_instr = data; m_pc = m_pc + 16'd2; m_upc = m_pc; end
            else begin m_held = 0; m_instr = 16'h0000; end
        end
        #1;
        check_regs("step");
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst.req", {15'd0, imemReq}, 16'h0000);
        check_regs("rst");
        @(posedge clk); #1; rst_n = 1'b1;

        // zero-wait streaming
        repeat (3) step(1, 0, 16'h0, 1);
        chk("stream.instr3", instruction, 16'hA5A1);
        chk("stream.upc3", updatedPC, 16'h0006);

        // stall holds, then resume at 0006
        step(1, 0, 16'h0, 0);
        step(0, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1);
        repeat (3) step(0, 0, 16'h0, $urandom_range(0, 1));
        step(1, 0, 16'h0, 1);

        // redirect while stalled in HOLD
        step(0, 1, 16'h0100, 1);
        chk("br.flush", {15'd0, IFFlush}, 16'h0001);
        step(1, 0, 16'h0, 1);
        chk("br.upc", updatedPC, 16'h0102);

        // redirect behind a 3-wait request to 0008
        step(0, 1, 16'h0008, 0);
        step(1, 0, 16'h0, 0);
        step(1, 1, 16'h0200, 0);
        step(1, 0, 16'h0, 0);
        chk("drop.flush_single", {15'd0, IFFlush}, 16'h0000);
        step(1, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1);
        chk("drop.upc", updatedPC, 16'h0202);

        // wrap at top of address space
        step(0, 1, 16'hFFFE, 1);
        step(1, 0, 16'h0, 1);
        chk("wrap.upc", updatedPC, 16'h0000);
        step(1, 0, 16'h0, 1);

        // back-to-back redirects, last target wins
        step(1, 1, 16'h0400, 1);
        step(1, 1, 16'h0500, 1);
        step(1, 0, 16'h0, 1);

        // async reset in the middle of DROP
        step(0, 1, 16'h0020, 0);
        step(1, 1, 16'h0300, 0);
        #2; rst_n = 1'b0; #1;
        model_reset();
        chk("rstdrop.req", {15'd0, imemReq}, 16'h0000);
        check_regs("rstdrop");
        @(posedge clk); #1; rst_n = 1'b1;
        step(1, 0, 16'h0, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE, $urandom_range(0, 2) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
